// File: rtl/ip_yuv_444.sv
// -----------------------------------------------------------------------------
// ip_yuv_444
//   Rebuilds an 8-bit-per-component YUV444 stream from a 16-bit YUV422 stream
//   (Y per beat, Cb/Cr interleaved across pixel pairs). It is the inverse of
//   the 444->422 down-sampler and sits on the receive side of the 422 link.
//   Chroma for an even pixel needs the Cr of the following odd beat, so the
//   beats run through a short look-ahead pipeline before the output register.
//
//   Optional feature (compile-time macro YUV_444_INTERP_EN):
//     undefined : chroma replicated across each pair, latency 3 clocks.
//     defined   : odd pixels take the truncated mean of pair k and pair k+1,
//                 latency 5 clocks.
//
// Ports
//   yuv_444_clk, yuv_444_rst_n    clock, asynchronous active-low reset
//   i_vstr/i_vend/i_hstr/i_hend   frame/line strobes aligned with i_dvld
//   i_dvld, i_422_data[15:0]      input beat valid and packed Y+C
//   r_yuv_swap_yc                 0: {Y,C}  1: {C,Y}  (quasi-static)
//   o_444_vstr/vend/hstr/hend     strobes delayed by the pipeline latency
//   o_444_dvld                    output pixel valid
//   o_444_data_y/cb/cr[7:0]       output components, zero when not valid
// -----------------------------------------------------------------------------
module ip_yuv_444 #(
  parameter logic [7:0] C_NEUTRAL = 8'h80
) (
  input  logic        yuv_444_clk,
  input  logic        yuv_444_rst_n,
  input  logic        i_vstr,
  input  logic        i_vend,
  input  logic        i_hstr,
  input  logic        i_hend,
  input  logic        i_dvld,
  input  logic [15:0] i_422_data,
  input  logic        r_yuv_swap_yc,
  output logic        o_444_vstr,
  output logic        o_444_vend,
  output logic        o_444_hstr,
  output logic        o_444_hend,
  output logic        o_444_dvld,
  output logic [7:0]  o_444_data_y,
  output logic [7:0]  o_444_data_cb,
  output logic [7:0]  o_444_data_cr
);

  // One unpacked input beat. strb = {vstr, vend, hstr, hend}.
  typedef struct packed {
    logic       vld;
    logic       ph;
    logic [3:0] strb;
    logic [7:0] y;
    logic [7:0] c;
  } beat_t;

  // Look-ahead stages ahead of the output register. The current pixel sits in
  // the last stage; earlier stages hold the beats that follow it.
`ifdef YUV_444_INTERP_EN
  localparam int C_DEPTH = 4;
`else
  localparam int C_DEPTH = 2;
`endif

  logic       r_phase;     // phase the next valid beat will take
  logic       w_beat_ph;
  beat_t      w_in;
  beat_t      r_pipe [C_DEPTH];
  logic [7:0] r_cb_hold;   // Cb of the pair whose odd pixel is being emitted
  logic [7:0] w_cb;
  logic [7:0] w_cr;

  logic       r_o_vld;
  logic [3:0] r_o_strb;
  logic [7:0] r_o_y;
  logic [7:0] r_o_cb;
  logic [7:0] r_o_cr;

`ifdef YUV_444_INTERP_EN
  // Truncated mean through a 9-bit sum.
  function automatic logic [7:0] avg(input logic [7:0] a, input logic [7:0] b);
    return 8'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction
`endif

  // Input unpacking and phase of the current beat (hstr always starts a pair).
  // NOTE: every always_comb output gets a value on every path, starting from a
  // default, so no latch can be inferred.
  always_comb begin
    w_beat_ph = i_hstr ? 1'b0 : r_phase;
    w_in.vld  = i_dvld;
    w_in.ph   = w_beat_ph;
    w_in.strb = {i_vstr, i_vend, i_hstr, i_hend};
    w_in.y    = r_yuv_swap_yc ? i_422_data[7:0]  : i_422_data[15:8];
    w_in.c    = r_yuv_swap_yc ? i_422_data[15:8] : i_422_data[7:0];
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge yuv_444_clk or negedge yuv_444_rst_n) begin
    if (!yuv_444_rst_n) begin
      r_phase <= 1'b0;
    end else if (!i_dvld) begin
      r_phase <= 1'b0;
    end else begin
      r_phase <= ~w_beat_ph;
    end
  end

  // Beat pipeline and pair latch.
  // NOTE: the pipeline is a handful of flops, not a RAM, so every stage is
  // reset; a reset mid-line therefore drops all in-flight beats.
  always_ff @(posedge yuv_444_clk or negedge yuv_444_rst_n) begin
    if (!yuv_444_rst_n) begin
      for (int i = 0; i < C_DEPTH; i++) r_pipe[i] <= '0;
      r_cb_hold <= '0;
    end else begin
      r_pipe[0] <= w_in;
      for (int i = 1; i < C_DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      if (r_pipe[C_DEPTH-1].vld && !r_pipe[C_DEPTH-1].ph)
        r_cb_hold <= r_pipe[C_DEPTH-1].c;
    end
  end

  // Chroma selection for the pixel in the last stage.
  always_comb begin
    w_cb = r_pipe[C_DEPTH-1].c;
    w_cr = C_NEUTRAL;
    if (!r_pipe[C_DEPTH-1].ph) begin
      // Even pixel: Cr comes from the odd beat directly behind it. A valid
      // phase-1 beat there can only be this pixel's partner; anything else
      // means the pixel is unpaired and gets the neutral Cr.
      if (r_pipe[C_DEPTH-2].vld && r_pipe[C_DEPTH-2].ph)
        w_cr = r_pipe[C_DEPTH-2].c;
    end else begin
      w_cb = r_cb_hold;
      w_cr = r_pipe[C_DEPTH-1].c;
`ifdef YUV_444_INTERP_EN
      // Interpolate only when pair k+1 is complete on the same line: this
      // pixel is not hend, the next beat continues the line, and the beat
      // after it carries Cr_{k+1}. An incomplete next pair counts as absent,
      // so the odd pixel replicates pair k rather than blending toward the
      // substituted neutral chroma.
      if (!r_pipe[3].strb[0] && r_pipe[2].vld && !r_pipe[2].strb[1] &&
          r_pipe[1].vld && r_pipe[1].ph) begin
        w_cb = avg(r_cb_hold, r_pipe[2].c);
        w_cr = avg(r_pipe[3].c, r_pipe[1].c);
      end
`endif
    end
  end

  // Output register; data is forced to zero outside valid pixels.
  always_ff @(posedge yuv_444_clk or negedge yuv_444_rst_n) begin
    if (!yuv_444_rst_n) begin
      r_o_vld  <= 1'b0;
      r_o_strb <= '0;
      r_o_y    <= '0;
      r_o_cb   <= '0;
      r_o_cr   <= '0;
    end else begin
      r_o_vld  <= r_pipe[C_DEPTH-1].vld;
      r_o_strb <= r_pipe[C_DEPTH-1].strb;
      r_o_y    <= r_pipe[C_DEPTH-1].vld ? r_pipe[C_DEPTH-1].y : 8'h00;
      r_o_cb   <= r_pipe[C_DEPTH-1].vld ? w_cb : 8'h00;
      r_o_cr   <= r_pipe[C_DEPTH-1].vld ? w_cr : 8'h00;
    end
  end

  assign o_444_vstr    = r_o_strb[3];
  assign o_444_vend    = r_o_strb[2];
  assign o_444_hstr    = r_o_strb[1];
  assign o_444_hend    = r_o_strb[0];
  assign o_444_dvld    = r_o_vld;
  assign o_444_data_y  = r_o_y;
  assign o_444_data_cb = r_o_cb;
  assign o_444_data_cr = r_o_cr;

endmodule

// File: tb/tb_ip_yuv_444.sv
// -----------------------------------------------------------------------------
// tb_ip_yuv_444
//   Directed-vector bench for ip_yuv_444. Each scenario queues input beats
//   together with the hand-computed output expected for each beat; run_seq
//   applies one beat per clock and compares the output latency cycles later.
//   Works for both builds of the YUV_444_INTERP_EN option.
// -----------------------------------------------------------------------------
module tb_ip_yuv_444;

`ifdef YUV_444_INTERP_EN
  localparam int         LAT   = 5;
  localparam logic [7:0] P1_CB = 8'h48;   // (40+50)>>1
  localparam logic [7:0] P1_CR = 8'h68;   // (60+70)>>1
`else
  localparam int         LAT   = 3;
  localparam logic [7:0] P1_CB = 8'h40;
  localparam logic [7:0] P1_CR = 8'h60;
`endif

  localparam logic [3:0] S_NONE = 4'b0000;
  localparam logic [3:0] S_HEND = 4'b0001;
  localparam logic [3:0] S_HSTR = 4'b0010;
  localparam logic [3:0] S_VEND = 4'b0100;
  localparam logic [3:0] S_VSTR = 4'b1000;

  typedef struct packed {
    logic       dvld;
    logic [3:0] strb;   // {vstr, vend, hstr, hend}
    logic [7:0] y;
    logic [7:0] c;
  } in_t;

  typedef struct packed {
    logic       dvld;
    logic [3:0] strb;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } out_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_vstr, i_vend, i_hstr, i_hend, i_dvld;
  logic [15:0] i_422_data;
  logic        swap;
  logic        o_444_vstr, o_444_vend, o_444_hstr, o_444_hend, o_444_dvld;
  logic [7:0]  o_444_data_y, o_444_data_cb, o_444_data_cr;

  int n_err = 0;
  int n_chk = 0;

  in_t  stim_q[$];
  out_t exp_q[$];

  ip_yuv_444 dut (
    .yuv_444_clk   (clk),
    .yuv_444_rst_n (rst_n),
    .i_vstr        (i_vstr),
    .i_vend        (i_vend),
    .i_hstr        (i_hstr),
    .i_hend        (i_hend),
    .i_dvld        (i_dvld),
    .i_422_data    (i_422_data),
    .r_yuv_swap_yc (swap),
    .o_444_vstr    (o_444_vstr),
    .o_444_vend    (o_444_vend),
    .o_444_hstr    (o_444_hstr),
    .o_444_hend    (o_444_hend),
    .o_444_dvld    (o_444_dvld),
    .o_444_data_y  (o_444_data_y),
    .o_444_data_cb (o_444_data_cb),
    .o_444_data_cr (o_444_data_cr)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input out_t e);
    check({tag, ".dvld"}, 32'(o_444_dvld), 32'(e.dvld));
    check({tag, ".strb"}, 32'({o_444_vstr, o_444_vend, o_444_hstr, o_444_hend}), 32'(e.strb));
    check({tag, ".y"},    32'(o_444_data_y),  32'(e.y));
    check({tag, ".cb"},   32'(o_444_data_cb), 32'(e.cb));
    check({tag, ".cr"},   32'(o_444_data_cr), 32'(e.cr));
  endtask

  // d is the pixel written as {Y, C}; the packing select is applied in drive.
  function automatic in_t bi(input logic v, input logic [3:0] s, input logic [15:0] d);
    in_t r;
    r.dvld = v;
    r.strb = s;
    r.y    = d[15:8];
    r.c    = d[7:0];
    return r;
  endfunction

  function automatic out_t bo(input logic v, input logic [3:0] s, input logic [7:0] y,
                              input logic [7:0] cb, input logic [7:0] cr);
    out_t r;
    r.dvld = v;
    r.strb = s;
    r.y    = y;
    r.cb   = cb;
    r.cr   = cr;
    return r;
  endfunction

  task automatic drive(input in_t b);
    i_dvld = b.dvld;
    {i_vstr, i_vend, i_hstr, i_hend} = b.strb;
    i_422_data = swap ? {b.c, b.y} : {b.y, b.c};
  endtask

  task automatic add(input in_t i, input out_t o);
    stim_q.push_back(i);
    exp_q.push_back(o);
  endtask

  // One beat per clock, driven on the falling edge; the output seen LAT
  // falling edges later belongs to that beat.
  task automatic run_seq(input string name);
    int n;
    n = stim_q.size();
    for (int j = 0; j < n + LAT + 1; j++) begin
      @(negedge clk);
      if (j >= LAT && j - LAT < n)
        check_out($sformatf("%s[%0d]", name, j - LAT), exp_q[j - LAT]);
      else
        check_out($sformatf("%s[idle%0d]", name, j), '0);
      if (j < n) drive(stim_q[j]);
      else       drive('0);
    end
    stim_q.delete();
    exp_q.delete();
  endtask

  task automatic add_line4();
    add(bi(1'b1, S_VSTR | S_HSTR, 16'h1040), bo(1'b1, S_VSTR | S_HSTR, 8'h10, 8'h40, 8'h60));
    add(bi(1'b1, S_NONE,          16'h2060), bo(1'b1, S_NONE,          8'h20, P1_CB, P1_CR));
    add(bi(1'b1, S_NONE,          16'h3050), bo(1'b1, S_NONE,          8'h30, 8'h50, 8'h70));
    add(bi(1'b1, S_VEND | S_HEND, 16'h4070), bo(1'b1, S_VEND | S_HEND, 8'h40, 8'h50, 8'h70));
    add('0, '0);
  endtask

  initial begin
    swap = 1'b0;
    drive('0);

    // Reset held, then released with no traffic.
    repeat (3) begin
      @(negedge clk);
      check_out("reset", '0);
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_out("idle", '0);
    end

    // 4-pixel line, {Y,C} packing.
    add_line4();
    run_seq("line4");

    // Same pixels packed as {C,Y}.
    swap = 1'b1;
    add_line4();
    run_seq("swap");
    swap = 1'b0;

    // Odd-length line: the last pixel has no Cr partner.
    add(bi(1'b1, S_HSTR, 16'h1040), bo(1'b1, S_HSTR, 8'h10, 8'h40, 8'h60));
    add(bi(1'b1, S_NONE, 16'h2060), bo(1'b1, S_NONE, 8'h20, 8'h40, 8'h60));
    add(bi(1'b1, S_HEND, 16'h3050), bo(1'b1, S_HEND, 8'h30, 8'h50, 8'h80));
    add('0, '0);
    run_seq("odd");

    // Back-to-back lines: hstr right after hend restarts pairing.
    add(bi(1'b1, S_HSTR, 16'h1040), bo(1'b1, S_HSTR, 8'h10, 8'h40, 8'h60));
    add(bi(1'b1, S_NONE, 16'h2060), bo(1'b1, S_NONE, 8'h20, 8'h40, 8'h60));
    add(bi(1'b1, S_HEND, 16'h3050), bo(1'b1, S_HEND, 8'h30, 8'h50, 8'h80));
    add(bi(1'b1, S_HSTR, 16'hA011), bo(1'b1, S_HSTR, 8'hA0, 8'h11, 8'h22));
    add(bi(1'b1, S_HEND, 16'hB022), bo(1'b1, S_HEND, 8'hB0, 8'h11, 8'h22));
    add('0, '0);
    run_seq("b2b");

    // dvld gap 1,0,1,1: first beat unpaired, pairing restarts after the gap.
    add(bi(1'b1, S_HSTR, 16'h1040), bo(1'b1, S_HSTR, 8'h10, 8'h40, 8'h80));
    add('0, '0);
    add(bi(1'b1, S_NONE, 16'h2055), bo(1'b1, S_NONE, 8'h20, 8'h55, 8'h66));
    add(bi(1'b1, S_HEND, 16'h3066), bo(1'b1, S_HEND, 8'h30, 8'h55, 8'h66));
    add('0, '0);
    run_seq("gap");

    // Reset asserted mid-line while valid pixels are in flight.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      drive(bi(1'b1, (k == 0) ? S_HSTR : S_NONE, 16'(16'h1040 + 16'(k) * 16'h1011)));
    end
    @(negedge clk);
    check("midline.dvld", 32'(o_444_dvld), 32'd1);
    drive('0);
    #2 rst_n = 1'b0;
    #1 check_out("rst_async", '0);
    repeat (2) begin
      @(negedge clk);
      check_out("rst_hold", '0);
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      check_out("post_rst", '0);
    end

    // Clean restart after reset.
    add_line4();
    run_seq("recover");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ip_yuv_444.md
Name: ip_yuv_444

Overview:
- Converts a 16-bit YUV422 pixel stream back to 8-bit-per-component YUV444. It is the inverse of the team's 444→422 down-sampler.
- Sits at the receive side of the 422 link, ahead of colour processing that needs full chroma.
- Recovers Y per pixel and rebuilds Cb/Cr per pixel from the Cb/Cr-interleaved pair.
- Sync strobes are delayed to stay aligned with the data.

Parameters:
- C_NEUTRAL, 8'h80, chroma value substituted for a missing Cr on an unpaired pixel.

Ports:
- yuv_444_clk  in  1  clock.
- yuv_444_rst_n  in  1  asynchronous active-low reset.
- i_vstr / i_vend / i_hstr / i_hend  in  1 each  frame/line start/end strobes, aligned with i_dvld.
- i_dvld  in  1  input pixel valid.
- i_422_data  in  16  packed Y+C pixel.
- r_yuv_swap_yc  in  1  packing select: 0 = {Y[15:8],C[7:0]}; 1 = {C[15:8],Y[7:0]}. Quasi-static.
- o_444_vstr / o_444_vend / o_444_hstr / o_444_hend  out  1 each  delayed strobes.
- o_444_dvld  out  1  output pixel valid.
- o_444_data_y  out  8  luma.
- o_444_data_cb  out  8  Cb.
- o_444_data_cr  out  8  Cr.

Behaviour:
- Reset: all outputs 0, all pipeline/holding registers 0, phase = 0.
- Clock and reset: single clock domain; reset asserts asynchronously and deasserts synchronously to yuv_444_clk.
- Phase bit:
  - Cleared whenever i_dvld = 0, and forced to 0 on a beat with i_hstr = 1.
  - Otherwise toggles on every valid beat.
  - Phase 0 beat = even pixel 2k, carrying Cb_k. Phase 1 beat = odd pixel 2k+1, carrying Cr_k.
- Unpacking: C and Y are extracted per r_yuv_swap_yc.
- Pair latch: Cb_k is captured on the phase-0 beat; Cr_k is captured on the phase-1 beat.
- Output chroma (base mode): pixels 2k and 2k+1 both output Cb = Cb_k and Cr = Cr_k.
- Latency:
  - Fixed 3 clocks from an input beat to its output beat, for every pixel.
  - vstr/vend/hstr/hend/dvld pass through the same 3-stage delay with no logic applied.
- Unpaired pixel: a phase-0 beat not followed by a valid beat (i_dvld falls, or odd line length) outputs Cb = Cb_k and Cr = C_NEUTRAL.
- Masking: o_444_data_y/cb/cr = 0 whenever o_444_dvld = 0.
- Gaps: an i_dvld gap mid-line restarts pairing at phase 0 on the next valid beat; the holding registers are not flushed.
- Back-to-back lines: no idle cycle is required. An i_hstr beat immediately after an i_hend beat starts a new pair at phase 0.
- Reset mid-line: all pipeline stages are dropped and no partial pixel is emitted. After release, output stays idle until the next input beat plus 3 clocks.
- Arithmetic: no arithmetic in base mode (pure selection).

Optional Feature:
- Macro: YUV_444_INTERP_EN.
- Defined:
  - Odd pixel 2k+1 gets Cb = (Cb_k + Cb_{k+1})[8:1] and Cr = (Cr_k + Cr_{k+1})[8:1], using a 9-bit sum with truncation.
  - Even pixel 2k keeps Cb_k/Cr_k.
  - For the last pair of a line (next pair absent, i.e. hend seen or dvld falls), the odd pixel replicates pair k.
  - Latency becomes 5 clocks for all data and strobes.
  - Unpaired-pixel rule is unchanged.
- Undefined: replication only, latency 3.

Test Plan:
- Reset/idle:
  - Stimulus: hold reset, then release with i_dvld = 0.
  - Response: all outputs 0; no o_444_dvld ever.
- 4-pixel line, swap = 0:
  - Stimulus: data = 1040, 2060, 3050, 4070 (hex) with hstr on beat 0, hend on beat 3.
  - Response, base mode, 3 clocks later: Y = 10, 20, 30, 40; Cb = 40, 40, 50, 50; Cr = 60, 60, 70, 70; hstr/hend aligned to pixels 0/3.
- Swap = 1:
  - Stimulus: same pixels packed as {C,Y}.
  - Response: identical outputs.
- Odd-length line:
  - Stimulus: 3 beats 1040, 2060, 3050, then i_dvld = 0.
  - Response: pixel 2 gives Y = 30, Cb = 50, Cr = 80 (hex); o_444_data_* = 0 on the following idle cycle.
- Gap and reset:
  - Stimulus: dvld pattern 1,0,1,1, then assert reset mid-line.
  - Response: first beat treated as unpaired (Cr = 80); pairing restarts after the gap; outputs go to 0 immediately on reset.
- YUV_444_INTERP_EN:
  - Stimulus: the 4-pixel line above.
  - Response at 5-clock latency: pixel 1 gives Cb = 48, Cr = 68 (hex); pixel 3 gives Cb = 50, Cr = 70.
